r5_pair_sequencer: RTL
======================

R5_PAIR_SEQUENCER -- requirements
Module: r5_pair_sequencer

Interface
REQ-001 The block SHALL have the parameter W, default 32, meaning the bit width of each real and imaginary word; data words are opaque and are never modified.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port in_re, input, W bits: the real part of the incoming sample.
REQ-005 The block SHALL have the port in_img, input, W bits: the imaginary part of the incoming sample.
REQ-006 The block SHALL have the port in_valid, input, 1 bit: the input sample is present.
REQ-007 The block SHALL have the port in_ready, output, 1 bit: the block accepts an input sample this cycle.
REQ-008 The block SHALL have the ports a_re and a_img, output, W bits each: the first operand of the pair.
REQ-009 The block SHALL have the ports b_re and b_img, output, W bits each: the second operand of the pair.
REQ-010 The block SHALL have the ports x0_re and x0_img, output, W bits each: sample 0 of the current frame.
REQ-011 The block SHALL have the port pair_idx, output, 1 bit: 0 marks pair (x1,x4) and 1 marks pair (x2,x3).
REQ-012 The block SHALL have the port out_valid, output, 1 bit: the pair outputs are valid.
REQ-013 The block SHALL have the port out_ready, input, 1 bit: the downstream half-FFT adder stage accepts the pair.

Function
REQ-014 An input transfer SHALL occur exactly on the cycles where in_valid and in_ready are both high; an output transfer SHALL occur exactly on the cycles where out_valid and out_ready are both high.
REQ-015 The state machine SHALL have the states FILL, PAIR0 and PAIR1.
REQ-016 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0; each input transfer SHALL write slot[cnt] and increment the 3-bit counter cnt, which runs from 0 to 4.
REQ-017 An input transfer with cnt==4 SHALL write slot 4, clear cnt to 0 and move the state to PAIR0 on the next cycle, so that out_valid rises in the cycle after the 5th sample is accepted (latency 1).
REQ-018 In PAIR0, outputs SHALL be a=slot1, b=slot4 and pair_idx=0; an output transfer SHALL move the state to PAIR1.
REQ-019 In PAIR1, outputs SHALL be a=slot2, b=slot3 and pair_idx=1; an output transfer SHALL move the state to FILL.
REQ-020 x0_re and x0_img SHALL present slot0 throughout PAIR0 and PAIR1.
REQ-021 in_ready SHALL be 0 in PAIR0 and PAIR1, so no input is accepted while pairs are issued.
REQ-022 While out_valid=1 and out_ready=0, the state and all outputs SHALL hold unchanged.
REQ-023 in_valid asserted outside FILL SHALL be ignored and SHALL cause no slot write.
REQ-024 in_valid gaps inside FILL SHALL leave cnt and the slots unchanged.
REQ-025 Back-to-back frames SHALL be supported: FILL is re-entered the cycle after the PAIR1 transfer, and in_ready=1 in that cycle.
REQ-026 in_ready and out_valid SHALL be decoded from state only, with no combinational path from in_valid or out_ready.

Reset
REQ-027 rst=1 at a clock edge SHALL set state=FILL and cnt=0, and SHALL clear all slots to 0, in priority over any transfer in the same cycle.
REQ-028 After reset, out_valid SHALL be 0, in_ready SHALL be 1, pair_idx SHALL be 0, and all data outputs SHALL be 0.
REQ-029 A reset in the middle of a frame (in FILL, PAIR0 or PAIR1) SHALL discard the partial frame, and no pair SHALL be emitted for it.

Structure
REQ-030 The state encoding (FILL=0, PAIR0=1, PAIR1=2), the frame length constant 5 and the default W SHALL live in the shared package r5_pkg.
REQ-031 The 5-entry complex slot register file SHALL be the sub-module r5_slot_regs, with a write port (index, re, img, we) and five read outputs; all other logic stays flat.

Verification
REQ-032 The bench SHALL cover: 5 consecutive samples re=k, img=10+k (k=0..4) with out_ready=1 -> out_valid high one cycle after the 5th sample; (a,b)=(1,4)/(11,14) with pair_idx=0, then (2,3)/(12,13) with pair_idx=1; x0=(0,10).
REQ-033 The bench SHALL cover: the same frame with out_ready=0 for 3 cycles during PAIR0 -> outputs stable for those 3 cycles, PAIR1 only after the handshake, in_ready=0 throughout.
REQ-034 The bench SHALL cover: in_valid toggling 1,0,1,0... over 10 cycles -> exactly 5 slots captured in order, and the pair sequence is as in REQ-032.
REQ-035 The bench SHALL cover: rst pulsed after 3 samples, then 5 new samples 20..24 -> the pairs use only 21/24 and 22/23, and no stale data appears.
REQ-036 The bench SHALL cover: two frames streamed with in_valid=1 and out_ready=1 continuously -> 5 accepted, 2 pairs out, 5 accepted, 2 pairs out; no sample is lost or duplicated, and in_ready=0 for exactly 2 cycles per frame.
REQ-037 The bench SHALL cover: in_valid=1 during PAIR0 and PAIR1 with distinct data -> the slots are unchanged, checked against the next frame's output.

Source files
------------

// File: rtl/r5_pkg.sv
// Shared definitions for the radix-5 pair sequencer: frame length, default
// word width and the sequencer state encoding.
package r5_pkg;

    localparam int W_DEFAULT = 32;
    localparam int FRAME_LEN = 5;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAIR0 = 2'd1,
        PAIR1 = 2'd2
    } state_t;

endpackage

// File: rtl/r5_slot_regs.sv
// Five-entry complex register file holding one radix-5 frame: a single write
// port and all five entries exposed as parallel read outputs.
module r5_slot_regs
    import r5_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [2:0]                    wr_idx,
    input  logic [W-1:0]                  wr_re,
    input  logic [W-1:0]                  wr_img,
    output logic [FRAME_LEN-1:0][W-1:0]   rd_re,
    output logic [FRAME_LEN-1:0][W-1:0]   rd_img
);

    // NOTE: the slots are built from flops, not RAM, so a reset clear is cheap
    // and guarantees a discarded frame never leaks stale words downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_re  <= '0;
            rd_img <= '0;
        end else if (we && (wr_idx < 3'(FRAME_LEN))) begin
            rd_re[wr_idx]  <= wr_re;
            rd_img[wr_idx] <= wr_img;
        end
    end

endmodule

// File: rtl/r5_pair_sequencer.sv
// Collects five complex samples per frame, then issues the symmetric pairs
// (x1,x4) and (x2,x3) alongside x0 to the half-FFT adder stage.
module r5_pair_sequencer
    import r5_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_img,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] a_re,
    output logic [W-1:0] a_img,
    output logic [W-1:0] b_re,
    output logic [W-1:0] b_img,
    output logic [W-1:0] x0_re,
    output logic [W-1:0] x0_img,
    output logic         pair_idx,
    output logic         out_valid,
    input  logic         out_ready
);

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic       wr_en;

    logic [FRAME_LEN-1:0][W-1:0] slot_re;
    logic [FRAME_LEN-1:0][W-1:0] slot_img;

    r5_slot_regs #(.W(W)) u_slots (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_en),
        .wr_idx (cnt),
        .wr_re  (in_re),
        .wr_img (in_img),
        .rd_re  (slot_re),
        .rd_img (slot_img)
    );

    // Handshake flags depend on state alone, keeping both ready/valid paths registered.
    assign in_ready  = (state == FILL);
    assign out_valid = (state != FILL);
    assign pair_idx  = (state == PAIR1);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_en      = 1'b0;
        unique case (state)
            FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (cnt == 3'(FRAME_LEN - 1)) begin
                        cnt_next   = '0;
                        state_next = PAIR0;
                    end else begin
                        cnt_next = cnt + 3'd1;
                    end
                end
            end
            PAIR0:   if (out_ready) state_next = PAIR1;
            PAIR1:   if (out_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Outside PAIR1 the (x1,x4) view is shown; it is only qualified by out_valid.
    always_comb begin
        a_re  = slot_re[1];
        a_img = slot_img[1];
        b_re  = slot_re[4];
        b_img = slot_img[4];
        if (state == PAIR1) begin
            a_re  = slot_re[2];
            a_img = slot_img[2];
            b_re  = slot_re[3];
            b_img = slot_img[3];
        end
    end

    assign x0_re  = slot_re[0];
    assign x0_img = slot_img[0];

endmodule
